// File: rtl/em_logic_ctrl_mc_if.sv
// Handshake and status bundle between the energy-monitor controller and its environment.
// slave: the controller side; master: the host/streamer/datapath side.
interface em_logic_ctrl_mc_if #(
    parameter int CNT_W     = 8,
    parameter int CH_W      = 2,
    parameter int JOB_CNT_W = 16
);
    logic                 en_i;
    logic                 flush_i;
    logic                 config_valid_i;
    logic                 config_ready_o;
    logic [CNT_W-1:0]     config_num_beats_i;
    logic                 spin_valid_i;
    logic                 spin_ready_o;
    logic [CH_W-1:0]      spin_ch_i;
    logic                 weight_valid_i;
    logic                 weight_ready_o;
    logic                 weight_last_o;
    logic                 acc_clr_o;
    logic [CNT_W-1:0]     beat_cnt_o;
    logic                 cmpt_done_i;
    logic                 energy_valid_o;
    logic                 energy_ready_i;
    logic [CH_W-1:0]      energy_ch_o;
    logic                 debug_en_i;
    logic                 debug_step_i;
    logic                 busy_o;
    logic [JOB_CNT_W-1:0] jobs_done_o;

    modport slave (
        input  en_i, flush_i, config_valid_i, config_num_beats_i, spin_valid_i, spin_ch_i,
               weight_valid_i, cmpt_done_i, energy_ready_i, debug_en_i, debug_step_i,
        output config_ready_o, spin_ready_o, weight_ready_o, weight_last_o, acc_clr_o,
               beat_cnt_o, energy_valid_o, energy_ch_o, busy_o, jobs_done_o
    );

    modport master (
        output en_i, flush_i, config_valid_i, config_num_beats_i, spin_valid_i, spin_ch_i,
               weight_valid_i, cmpt_done_i, energy_ready_i, debug_en_i, debug_step_i,
        input  config_ready_o, spin_ready_o, weight_ready_o, weight_last_o, acc_clr_o,
               beat_cnt_o, energy_valid_o, energy_ch_o, busy_o, jobs_done_o
    );
endinterface

// File: rtl/em_logic_ctrl_mc.sv
// Energy-monitor job sequencer: config, spin load, N weight beats, pipeline drain, result handshake.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  S_IDLE    | waiting for a config update or a spin job
//  S_COMPUTE | accepting weight beats until num_beats have been taken
//  S_DRAIN   | letting the datapath pipeline empty, then waiting cmpt_done
//  S_RESULT  | presenting energy_valid/energy_ch until the consumer takes it
module em_logic_ctrl_mc #(
    parameter int NUM_CH            = 4,
    parameter int CNT_W             = 8,
    parameter int NUM_BEATS_DEFAULT = 16,
    parameter int PIPE_DEPTH        = 1,
    parameter int JOB_CNT_W         = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    em_logic_ctrl_mc_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DRN_W = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_num_beats;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [DRN_W-1:0]     r_drain_cnt;
    logic [CH_W-1:0]      r_ch;
    logic [JOB_CNT_W-1:0] r_jobs_done;

    logic w_go;
    logic w_cfg_rdy;
    logic w_spin_rdy;
    logic w_wt_rdy;
    logic w_ev;
    logic w_cfg_hs;
    logic w_spin_hs;
    logic w_wt_hs;
    logic w_res_hs;
    logic w_last;
    logic w_drain_exit;
    logic [CNT_W-1:0] w_cfg_beats;

    // Debug mode turns every progress condition into a single-step strobe.
    assign w_go         = bus.en_i & (~bus.debug_en_i | bus.debug_step_i);
    assign w_cfg_hs     = bus.config_valid_i & w_cfg_rdy;
    assign w_spin_hs    = bus.spin_valid_i & w_spin_rdy;
    assign w_wt_hs      = bus.weight_valid_i & w_wt_rdy;
    // Result handshake ignores en/debug so a stalled host can still drain the result.
    assign w_res_hs     = w_ev & bus.energy_ready_i;
    assign w_last       = w_wt_hs & (r_beat_cnt == r_num_beats - CNT_ONE);
    assign w_drain_exit = w_go & (r_drain_cnt == '0) & bus.cmpt_done_i;
    // A zero beat count would never finish a job, so it is promoted to one.
    assign w_cfg_beats  = (bus.config_num_beats_i == '0) ? CNT_ONE : bus.config_num_beats_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_spin_hs)    w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_last)       w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_drain_exit) w_state_nxt = S_RESULT;
            S_RESULT:  if (w_res_hs)     w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Handshake readies and result valid, decoded from the current state.
    always_comb begin
        w_cfg_rdy  = 1'b0;
        w_spin_rdy = 1'b0;
        w_wt_rdy   = 1'b0;
        w_ev       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cfg_rdy  = w_go;
                w_spin_rdy = w_go & ~bus.config_valid_i;
            end
            S_COMPUTE: w_wt_rdy = w_go & (r_beat_cnt < r_num_beats);
            S_RESULT:  w_ev     = 1'b1;
            default:   w_ev     = 1'b0;
        endcase
    end

    // Job counters, channel tag and programmed beat count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_num_beats <= CNT_W'(NUM_BEATS_DEFAULT);
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_ch        <= '0;
            r_jobs_done <= '0;
        end else begin
            if (w_cfg_hs) begin
                r_num_beats <= w_cfg_beats;
            end
            if (w_res_hs) begin
                r_jobs_done <= r_jobs_done + JOB_CNT_W'(1);
            end
            if (bus.flush_i) begin
                r_beat_cnt  <= '0;
                r_drain_cnt <= '0;
            end else begin
                if (w_spin_hs) begin
                    r_ch       <= bus.spin_ch_i;
                    r_beat_cnt <= '0;
                end else if (w_wt_hs) begin
                    r_beat_cnt <= r_beat_cnt + CNT_ONE;
                end
                if (w_last) begin
                    r_drain_cnt <= DRN_W'(PIPE_DEPTH);
                end else if ((r_state == S_DRAIN) && w_go && (r_drain_cnt != '0)) begin
                    r_drain_cnt <= r_drain_cnt - DRN_W'(1);
                end
            end
        end
    end

    assign bus.config_ready_o = w_cfg_rdy;
    assign bus.spin_ready_o   = w_spin_rdy;
    assign bus.weight_ready_o = w_wt_rdy;
    assign bus.weight_last_o  = w_last;
    assign bus.acc_clr_o      = w_spin_hs;
    assign bus.beat_cnt_o     = r_beat_cnt;
    assign bus.energy_valid_o = w_ev;
    assign bus.energy_ch_o    = r_ch;
    assign bus.busy_o         = (r_state != S_IDLE);
    assign bus.jobs_done_o    = r_jobs_done;
endmodule

// File: tb/tb_em_logic_ctrl_mc.sv
// Bench for em_logic_ctrl_mc: directed job scenarios with literal expectations, then random traffic,
// with a job-level reference model compared against the DUT every cycle.
module tb_em_logic_ctrl_mc;
    localparam int PIPE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   model_on = 1'b0;

    always #5 clk = ~clk;

    em_logic_ctrl_mc_if #(.CNT_W(8), .CH_W(2), .JOB_CNT_W(16)) bus ();

    em_logic_ctrl_mc #(
        .NUM_CH(4), .CNT_W(8), .NUM_BEATS_DEFAULT(16), .PIPE_DEPTH(PIPE), .JOB_CNT_W(16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a job is "phase" (0 idle, 1 taking beats, 2 waiting on pipeline, 3 result),
    // with beats still owed and pipeline wait cycles remaining.
    int          m_phase = 0;
    int          m_need  = 16;
    int          m_got   = 0;
    int          m_wait  = 0;
    logic [1:0]  m_ch    = '0;
    logic [15:0] m_jobs  = '0;

    always @(negedge clk) begin : model_blk
        logic go, e_cfg, e_spin, e_wt, e_last, e_ev, cfg_hs, spin_hs, wt_hs, res_hs;
        if (model_on) begin
            go      = bus.en_i & (!bus.debug_en_i | bus.debug_step_i);
            e_cfg   = (m_phase == 0) & go;
            e_spin  = (m_phase == 0) & go & !bus.config_valid_i;
            e_wt    = (m_phase == 1) & go & (m_got < m_need);
            e_ev    = (m_phase == 3);
            cfg_hs  = e_cfg & bus.config_valid_i;
            spin_hs = e_spin & bus.spin_valid_i;
            wt_hs   = e_wt & bus.weight_valid_i;
            res_hs  = e_ev & bus.energy_ready_i;
            e_last  = wt_hs & (m_got + 1 == m_need);

            chk("m_config_ready", 32'(bus.config_ready_o), 32'(e_cfg));
            chk("m_spin_ready",   32'(bus.spin_ready_o),   32'(e_spin));
            chk("m_weight_ready", 32'(bus.weight_ready_o), 32'(e_wt));
            chk("m_weight_last",  32'(bus.weight_last_o),  32'(e_last));
            chk("m_acc_clr",      32'(bus.acc_clr_o),      32'(spin_hs));
            chk("m_beat_cnt",     32'(bus.beat_cnt_o),     32'(m_got));
            chk("m_energy_valid", 32'(bus.energy_valid_o), 32'(e_ev));
            chk("m_busy",         32'(bus.busy_o),         32'(m_phase != 0));
            chk("m_jobs_done",    32'(bus.jobs_done_o),    32'(m_jobs));
            if (e_ev) chk("m_energy_ch", 32'(bus.energy_ch_o), 32'(m_ch));

            if (rst) begin
                m_phase = 0; m_need = 16; m_got = 0; m_wait = 0; m_ch = '0; m_jobs = '0;
            end else begin
                if (cfg_hs) m_need = (bus.config_num_beats_i == 0) ? 1 : int'(bus.config_num_beats_i);
                if (res_hs) m_jobs = m_jobs + 16'd1;
                if (bus.flush_i) begin
                    m_phase = 0; m_got = 0; m_wait = 0;
                end else if (m_phase == 0) begin
                    if (spin_hs) begin m_phase = 1; m_got = 0; m_ch = bus.spin_ch_i; end
                end else if (m_phase == 1) begin
                    if (wt_hs) m_got++;
                    if (m_got == m_need) begin m_phase = 2; m_wait = PIPE; end
                end else if (m_phase == 2) begin
                    if (go) begin
                        if (m_wait == 0 && bus.cmpt_done_i) m_phase = 3;
                        else if (m_wait > 0) m_wait--;
                    end
                end else begin
                    if (res_hs) m_phase = 0;
                end
            end
        end
    end

    task automatic wait_ev(input string name);
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (bus.energy_valid_o) break;
        end
        chk(name, 32'(bus.energy_valid_o), 32'd1);
    endtask

    initial begin
        int cnt;
        bus.en_i = 1; bus.flush_i = 0; bus.config_valid_i = 0; bus.config_num_beats_i = '0;
        bus.spin_valid_i = 0; bus.spin_ch_i = '0; bus.weight_valid_i = 0; bus.cmpt_done_i = 1;
        bus.energy_ready_i = 0; bus.debug_en_i = 0; bus.debug_step_i = 0;

        tick();
        model_on = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_jobs", 32'(bus.jobs_done_o), 32'd0);
        tick();

        // 1: cfg 4, spin ch 2, four beats, result three cycles after the last beat
        bus.config_valid_i = 1; bus.config_num_beats_i = 8'd4;
        @(negedge clk); chk("t1_cfg_ready", 32'(bus.config_ready_o), 32'd1);
        tick();
        bus.config_valid_i = 0; bus.spin_valid_i = 1; bus.spin_ch_i = 2'd2;
        @(negedge clk); chk("t1_acc_clr", 32'(bus.acc_clr_o), 32'd1);
        tick();
        bus.spin_valid_i = 0; bus.weight_valid_i = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); chk("t1_weight_last", 32'(bus.weight_last_o), 32'(i == 4));
            tick();
        end
        bus.weight_valid_i = 0;
        @(negedge clk); chk("t1_ev_t1", 32'(bus.energy_valid_o), 32'd0);
        tick();
        @(negedge clk); chk("t1_ev_t2", 32'(bus.energy_valid_o), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_ev_t3", 32'(bus.energy_valid_o), 32'd1);
        chk("t1_ch", 32'(bus.energy_ch_o), 32'd2);

        // 2: result back-pressured for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("t2_ev_hold", 32'(bus.energy_valid_o), 32'd1);
            chk("t2_ch_hold", 32'(bus.energy_ch_o), 32'd2);
            chk("t2_spin_ready", 32'(bus.spin_ready_o), 32'd0);
            chk("t2_beat_cnt", 32'(bus.beat_cnt_o), 32'd4);
        end
        tick();
        bus.energy_ready_i = 1;
        @(negedge clk);
        tick();
        bus.energy_ready_i = 0;
        @(negedge clk);
        chk("t2_idle", 32'(bus.busy_o), 32'd0);
        chk("t2_jobs", 32'(bus.jobs_done_o), 32'd1);
        tick();

        // 3: debug single-step, three strobes give exactly three beats
        bus.spin_valid_i = 1; bus.spin_ch_i = 2'd1;
        tick();
        bus.spin_valid_i = 0; bus.debug_en_i = 1; bus.weight_valid_i = 1;
        for (int i = 0; i < 12; i++) begin
            bus.debug_step_i = (i % 4 == 1);
            tick();
        end
        bus.debug_step_i = 0;
        @(negedge clk);
        chk("t3_beat_cnt", 32'(bus.beat_cnt_o), 32'd3);
        chk("t3_no_ready", 32'(bus.weight_ready_o), 32'd0);
        tick();
        bus.flush_i = 1; bus.weight_valid_i = 0; bus.debug_en_i = 0;
        tick();
        bus.flush_i = 0;

        // 4: flush after two of four beats, then a clean job
        bus.spin_valid_i = 1; bus.spin_ch_i = 2'd3;
        tick();
        bus.spin_valid_i = 0; bus.weight_valid_i = 1;
        tick();
        tick();
        bus.weight_valid_i = 0; bus.flush_i = 1;
        @(negedge clk); chk("t4_two_beats", 32'(bus.beat_cnt_o), 32'd2);
        tick();
        bus.flush_i = 0;
        @(negedge clk);
        chk("t4_idle", 32'(bus.busy_o), 32'd0);
        chk("t4_beat_clr", 32'(bus.beat_cnt_o), 32'd0);
        chk("t4_jobs", 32'(bus.jobs_done_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk); chk("t4_no_ev", 32'(bus.energy_valid_o), 32'd0);
        end
        tick();
        bus.spin_valid_i = 1;
        tick();
        bus.spin_valid_i = 0; bus.weight_valid_i = 1;
        wait_ev("t4_ev_timeout");
        chk("t4_ch", 32'(bus.energy_ch_o), 32'd3);
        tick();
        bus.weight_valid_i = 0; bus.energy_ready_i = 1;
        tick();
        bus.energy_ready_i = 0;
        @(negedge clk); chk("t4_jobs_after", 32'(bus.jobs_done_o), 32'd2);
        tick();

        // 5: cfg 0 and spin together: config wins, then jobs take one beat
        bus.config_valid_i = 1; bus.config_num_beats_i = 8'd0; bus.spin_valid_i = 1; bus.spin_ch_i = 2'd0;
        @(negedge clk);
        chk("t5_cfg_ready", 32'(bus.config_ready_o), 32'd1);
        chk("t5_spin_blocked", 32'(bus.spin_ready_o), 32'd0);
        chk("t5_no_clr", 32'(bus.acc_clr_o), 32'd0);
        tick();
        bus.config_valid_i = 0;
        @(negedge clk); chk("t5_spin_taken", 32'(bus.acc_clr_o), 32'd1);
        tick();
        bus.spin_valid_i = 0; bus.weight_valid_i = 1;
        @(negedge clk); chk("t5_first_is_last", 32'(bus.weight_last_o), 32'd1);
        tick();
        bus.weight_valid_i = 0;
        @(negedge clk);
        chk("t5_no_more_beats", 32'(bus.weight_ready_o), 32'd0);
        chk("t5_beat_cnt", 32'(bus.beat_cnt_o), 32'd1);
        wait_ev("t5_ev_timeout");
        tick();
        bus.energy_ready_i = 1;
        tick();
        bus.energy_ready_i = 0;
        @(negedge clk); chk("t5_jobs", 32'(bus.jobs_done_o), 32'd3);
        tick();

        // 6: reset while in RESULT restores reset values, including 16 beats per job
        bus.spin_valid_i = 1;
        tick();
        bus.spin_valid_i = 0; bus.weight_valid_i = 1;
        wait_ev("t6_ev_timeout");
        tick();
        bus.weight_valid_i = 0; rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("t6_ev", 32'(bus.energy_valid_o), 32'd0);
        chk("t6_jobs", 32'(bus.jobs_done_o), 32'd0);
        chk("t6_busy", 32'(bus.busy_o), 32'd0);
        tick();
        bus.spin_valid_i = 1;
        tick();
        bus.spin_valid_i = 0; bus.weight_valid_i = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.weight_ready_o && bus.weight_valid_i) cnt++;
            if (bus.weight_last_o) break;
            tick();
        end
        chk("t6_default_beats", 32'(cnt), 32'd16);
        tick();
        bus.weight_valid_i = 0;
        wait_ev("t6_ev2_timeout");
        tick();
        bus.energy_ready_i = 1;
        tick();
        bus.energy_ready_i = 0;

        // Random traffic, checked by the model every cycle
        repeat (4000) begin
            rst                    = ($urandom_range(0, 499) == 0);
            bus.en_i               = ($urandom_range(0, 9) != 0);
            bus.debug_en_i         = ($urandom_range(0, 6) == 0);
            bus.debug_step_i       = $urandom_range(0, 1);
            bus.flush_i            = ($urandom_range(0, 49) == 0);
            bus.config_valid_i     = ($urandom_range(0, 9) == 0);
            bus.config_num_beats_i = 8'($urandom_range(0, 6));
            bus.spin_valid_i       = $urandom_range(0, 1);
            bus.spin_ch_i          = 2'($urandom_range(0, 3));
            bus.weight_valid_i     = ($urandom_range(0, 9) < 7);
            bus.cmpt_done_i        = ($urandom_range(0, 9) < 7);
            bus.energy_ready_i     = $urandom_range(0, 1);
            tick();
        end
        rst = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
